// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor.
package serial_subtractor_pkg;

    // Controller states: waiting, stepping through digits, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_digit.sv
// Combinational DIGIT-bit ripple subtractor used once per clock by the serial datapath.
module digit_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] chain;

    // Ripple the borrow bit by bit from the digit LSB towards its MSB.
    always_comb begin
        chain    = '0;
        d        = '0;
        chain[0] = bin;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]         = x[i] ^ y[i] ^ chain[i];
            chain[i+1]   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain[i]);
        end
    end

    assign bout = chain[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - bin one DIGIT-bit slice per clock,
// LSB slice first, reporting diff, unsigned borrow and signed overflow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // A width that does not split into whole digits has no meaningful schedule.
    if (DIGIT < 1 || (WIDTH % ((DIGIT > 0) ? DIGIT : 1)) != 0) begin : g_cfg_check
        $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             a_msb;
    logic             b_msb;
    logic             chain;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dig_d;
    logic             dig_bout;

    // The operands shift right so the digit being worked on is always at bit 0.
    digit_subtractor #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x    (a_sh[DIGIT-1:0]),
        .y    (b_sh[DIGIT-1:0]),
        .bin  (chain),
        .d    (dig_d),
        .bout (dig_bout)
    );

    assign last   = (cnt == CW'(N - 1));
    assign borrow = chain;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake decode; start is only honoured outside RUN.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then consume one digit per RUN cycle,
    // shifting result digits in from the top so diff is aligned once finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            chain    <= 1'b0;
            cnt      <= '0;
            diff     <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            chain <= bin;
            cnt   <= '0;
        end else if (step) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            chain <= dig_bout;
            cnt   <= cnt + CW'(1);
            diff  <= (diff >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));
            if (last) begin
                overflow <= (a_msb != b_msb) && (dig_d[DIGIT-1] != a_msb);
            end
        end
    end

endmodule
